// File: rtl/sclkfifolut_pkg.sv
// sclkfifolut_pkg
// Shared constants and helpers for the single-clock LUT FIFO.
//   FIFO_MODE_STD  : rdata is registered and updates on an accepted read.
//   FIFO_MODE_FWFT : the head word is presented on rdata whenever not empty.
//   fifo_level()   : occupancy from a write/read pointer pair of ptr_w bits.
package sclkfifolut_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry a wrap bit above the index bits, so a plain modulo
    // subtraction over ptr_w bits yields 0..depth without ambiguity.
    function automatic logic [31:0] fifo_level(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifolut_mem.sv
// fifolut_mem
// Simple dual-port distributed (LUT) RAM: synchronous write, asynchronous read.
// Ports:
//   clk            write clock
//   we/waddr/wdata write port, sampled on the rising edge
//   raddr/rdata    combinational read port
module fifolut_mem #(
    parameter int LOG2_FIFO_DEPTH = 3,
    parameter int FIFO_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [LOG2_FIFO_DEPTH-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]      wdata,
    input  logic [LOG2_FIFO_DEPTH-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;

    // Contents are intentionally never reset; the FIFO pointers guard them.
    logic [FIFO_WIDTH-1:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    assign rdata = mem_array[raddr];

endmodule

// File: rtl/sclkfifolut.sv
// sclkfifolut
// Single-clock FIFO on LUT memory with selectable read mode, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports:
//   clk, srst           clock and synchronous active-high reset
//   wen, wdata          write request and data (dropped while full)
//   ren                 read request / pop (ignored while empty)
//   rdata               read data (registered in STD mode, head word in FWFT)
//   empty, full, level  registered occupancy status
//   almost_empty/full   level <= AEMPTY_LEVEL / level >= AFULL_LEVEL
//   overflow/underflow  sticky error flags, cleared only by srst
module sclkfifolut
    import sclkfifolut_pkg::*;
#(
    parameter int LOG2_FIFO_DEPTH = 3,
    parameter int FIFO_WIDTH      = 8,
    parameter int FWFT            = 0,
    parameter int AFULL_LEVEL     = 2**LOG2_FIFO_DEPTH - 2,
    parameter int AEMPTY_LEVEL    = 1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wen,
    input  logic [FIFO_WIDTH-1:0]    wdata,
    input  logic                     ren,
    output logic [FIFO_WIDTH-1:0]    rdata,
    output logic                     empty,
    output logic                     full,
    output logic [LOG2_FIFO_DEPTH:0] level,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW    = LOG2_FIFO_DEPTH + 1;
    localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

    logic [PW-1:0] wptr_reg, wptr_next;
    logic [PW-1:0] rptr_reg, rptr_next;
    logic [PW-1:0] level_reg, level_next;
    logic          empty_reg, full_reg;
    logic          aempty_reg, afull_reg;
    logic          overflow_reg, underflow_reg;
    logic          wr_acc, rd_acc;
    logic [FIFO_WIDTH-1:0] mem_rdata;

    // Acceptance uses only registered status, so wen/ren never reach an
    // output combinationally.
    always_comb begin
        wr_acc     = wen && !full_reg;
        rd_acc     = ren && !empty_reg;
        wptr_next  = wptr_reg + PW'(wr_acc);
        rptr_next  = rptr_reg + PW'(rd_acc);
        level_next = PW'(fifo_level(32'(wptr_next), 32'(rptr_next), PW));
    end

    // Status is registered from the next-state pointers so it reflects the
    // edge at which an operation was accepted.
    always_ff @(posedge clk) begin
        if (srst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            level_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            aempty_reg    <= 1'b1;
            afull_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg   <= wptr_next;
            rptr_reg   <= rptr_next;
            level_reg  <= level_next;
            empty_reg  <= (level_next == '0);
            full_reg   <= (level_next == DEPTH_L);
            aempty_reg <= (level_next <= AEMPTY_L);
            afull_reg  <= (level_next >= AFULL_L);
            if (wen && full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (ren && empty_reg) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifolut_mem #(
        .LOG2_FIFO_DEPTH (LOG2_FIFO_DEPTH),
        .FIFO_WIDTH      (FIFO_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_reg[LOG2_FIFO_DEPTH-1:0]),
        .wdata (wdata),
        .raddr (rptr_reg[LOG2_FIFO_DEPTH-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word falls through; masked to zero so stale memory never
            // shows while empty (this also gives rdata = 0 after reset).
            assign rdata = empty_reg ? '0 : mem_rdata;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] rdata_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    rdata_reg <= '0;
                end else if (rd_acc) begin
                    rdata_reg <= mem_rdata;
                end
            end
            assign rdata = rdata_reg;
        end
    endgenerate

    assign empty        = empty_reg;
    assign full         = full_reg;
    assign level        = level_reg;
    assign almost_empty = aempty_reg;
    assign almost_full  = afull_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
